// File: rtl/decod_scan_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct and scan modes.
// Optional skip mask for the scan walk: define DEC_SKIP_MASK_EN.
module decod_scan_seq #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
`ifdef DEC_SKIP_MASK_EN
  input  logic [(1<<SEL_W)-1:0]   skip_mask,
`endif
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [7:0] LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t           state;
  logic [7:0]       dwell_cnt;
  logic             paused;   // scan was interrupted by en=0; resume at held idx
  logic [SEL_W-1:0] nxt;
  logic             nxt_ok;
  logic             step;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction

`ifdef DEC_SKIP_MASK_EN
  // Descending search so the nearest unmasked index after idx wins; k=OUT_W is idx itself.
  always_comb begin
    logic [SEL_W-1:0] cand;
    nxt    = idx;
    nxt_ok = 1'b0;
    for (int k = OUT_W; k >= 1; k--) begin
      cand = idx + SEL_W'(k);
      if (!skip_mask[cand]) begin
        nxt    = cand;
        nxt_ok = 1'b1;
      end
    end
  end
  assign step = (dwell_cnt == LAST) || skip_mask[idx] || (out == '0);
`else
  assign nxt    = idx + 1'b1;
  assign nxt_ok = 1'b1;
  assign step   = (dwell_cnt == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      idx       <= '0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
      paused    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        out       <= '0;
        dwell_cnt <= '0;
        if (state == SCAN) paused <= 1'b1;
      end else if (!mode) begin
        state     <= DIRECT;
        out       <= onehot(sel);
        idx       <= sel;
        dwell_cnt <= '0;
        paused    <= 1'b0;
      end else begin
        state <= SCAN;
        if (state == DIRECT || (state == IDLE && !paused)) begin
          idx       <= sel;
          out       <= onehot(sel);
          dwell_cnt <= '0;
        end else if (state == IDLE) begin
          out       <= onehot(idx);
          dwell_cnt <= '0;
        end else if (step) begin
          dwell_cnt <= '0;
          if (nxt_ok) begin
            idx  <= nxt;
            out  <= onehot(nxt);
            wrap <= (nxt < idx);
          end else begin
            out <= '0;
          end
        end else begin
          dwell_cnt <= dwell_cnt + 8'd1;
        end
      end
    end
  end
endmodule
